neuron_mac_seq: RTL

- Sequential neuron pre-activation stage. It sits directly upstream of the tanh approximation unit.
- Accepts N_INPUTS streamed (x, w) signed fixed-point pairs and multiply-accumulates them. It then adds a bias, saturates to 32 bits and drives the tanh unit through its level-enable/done handshake.
- Captures the activation result and presents it with a one-cycle valid pulse to the downstream consumer (bus register / next layer).

---
 rtl/neuron_mac_seq_if.sv | 29 ++
 rtl/neuron_mac_seq.sv | 136 +++++++++++++
 2 files changed

// File: rtl/neuron_mac_seq_if.sv
// Interface bundling the neuron MAC's handshake and data signals.
// The slave modport is the MAC itself. The master modport is its environment:
// the upstream feeder, the tanh unit and the downstream consumer.
interface neuron_mac_seq_if;
  logic        start;
  logic [31:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in;
  logic [31:0] w_in;
  logic        act_en;
  logic [31:0] act_data;
  logic        act_done;
  logic [31:0] act_result;
  logic [31:0] y_out;
  logic        y_valid;
  logic        overflow;
  logic        busy;

  modport slave (
    input  start, bias, in_valid, x_in, w_in, act_done, act_result,
    output in_ready, act_en, act_data, y_out, y_valid, overflow, busy
  );

  modport master (
    output start, bias, in_valid, x_in, w_in, act_done, act_result,
    input  in_ready, act_en, act_data, y_out, y_valid, overflow, busy
  );
endinterface

// File: rtl/neuron_mac_seq.sv
// Sequential neuron pre-activation stage.
// Streams N_INPUTS signed fixed-point (x, w) pairs and multiply-accumulates them
// into a 64-bit accumulator. It then adds the bias and clamps the sum to 32 bits.
// The clamped value drives the tanh unit over a level-enable/done handshake.
// The activation result is captured and presented with a one-cycle valid pulse.
module neuron_mac_seq #(
  parameter int unsigned N_INPUTS  = 8,
  parameter int unsigned FRAC_BITS = 14
) (
  input  logic              clk,
  input  logic              rstn,
  neuron_mac_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    BIAS,
    SAT,
    ACT,
    DRAIN
  } state_t;

  localparam logic [7:0]         LAST_IDX = 8'(N_INPUTS - 1);
  localparam logic signed [63:0] SAT_MAX  = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] SAT_MIN  = 64'shFFFF_FFFF_8000_0000;

  state_t             state;
  state_t             state_nx;

  logic signed [63:0] acc;
  logic signed [63:0] prod;
  logic signed [63:0] term;
  logic [31:0]        bias_q;
  logic [7:0]         count;
  logic [31:0]        act_data_q;
  logic [31:0]        y_out_q;
  logic               y_valid_q;
  logic               overflow_q;
  logic               accept;
  logic               start_ok;

  // Full-precision signed product, floored back to the fixed-point scale
  always_comb begin
    prod = $signed({{32{bus.x_in[31]}}, bus.x_in}) *
           $signed({{32{bus.w_in[31]}}, bus.w_in});
    term = prod >>> FRAC_BITS;
  end

  assign accept   = (state == ACCUM) && bus.in_valid;
  assign start_ok = bus.start && !bus.act_done;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic for the evaluation sequence
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = ACCUM;
      ACCUM:   if (accept && (count == LAST_IDX)) state_nx = BIAS;
      BIAS:    state_nx = SAT;
      SAT:     state_nx = ACT;
      ACT:     if (bus.act_done) state_nx = DRAIN;
      DRAIN:   if (!bus.act_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: accumulate, add bias, clamp, capture the activation result
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc        <= '0;
      count      <= '0;
      bias_q     <= '0;
      act_data_q <= '0;
      y_out_q    <= '0;
      y_valid_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            bias_q     <= bus.bias;
            acc        <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc   <= acc + term;
            count <= count + 8'd1;
          end
        end
        BIAS: begin
          acc <= acc + {{32{bias_q[31]}}, bias_q};
        end
        SAT: begin
          if (acc > SAT_MAX) begin
            act_data_q <= 32'h7FFF_FFFF;
            overflow_q <= 1'b1;
          end else if (acc < SAT_MIN) begin
            act_data_q <= 32'h8000_0000;
            overflow_q <= 1'b1;
          end else begin
            act_data_q <= acc[31:0];
          end
        end
        ACT: begin
          if (bus.act_done) begin
            y_out_q   <= bus.act_result;
            y_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = (state == ACCUM);
  assign bus.act_en   = (state == ACT);
  assign bus.busy     = (state != IDLE);
  assign bus.act_data = act_data_q;
  assign bus.y_out    = y_out_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.overflow = overflow_q;

endmodule
